sram_responder: RTL and testbench

- Synchronous behavioural responder for the small embedded SRAM: the device end of the CE/WE/OE/AD/DT interface that the RAM front-end drives.
- It holds a 2^ADDR_W x DATA_W array and answers chip-enable, write-enable and output-enable strobes (all active-low).
- It drives the shared DT bus on reads with a programmable access latency.
- It is used as the on-chip SRAM stand-in for board bring-up and as the bench target for the front-end.

---
 rtl/sram_responder_pkg.sv | 23 ++
 rtl/sram_responder_if.sv | 26 ++
 rtl/sram_responder_array.sv | 42 ++++
 rtl/sram_responder.sv | 155 +++++++++++++++
 tb/tb_sram_responder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sram_responder_pkg.sv
// ---------------------------------------------------------------------------
// sram_responder_pkg
// Purpose : shared types and default constants for the SRAM responder slice.
// Contents: state_t   - responder FSM encoding (5 states, 3 bits)
//           *_DEF     - default geometry / access latency
//           WCOUNT_MAX- saturation value of the committed-write counter
// ---------------------------------------------------------------------------
package sram_responder_pkg;

    localparam int ADDR_W_DEF       = 4;
    localparam int DATA_W_DEF       = 4;
    localparam int READ_LATENCY_DEF = 2;
    localparam int WCOUNT_MAX       = 255;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_COMMIT     = 3'd2,
        ST_READ_WAIT  = 3'd3,
        ST_READ_DRIVE = 3'd4
    } state_t;

endpackage

// File: rtl/sram_responder_if.sv
// ---------------------------------------------------------------------------
// sram_responder_if
// Purpose : strobe/address/status bundle between the RAM front-end (master)
//           and the SRAM responder (slave).
// Signals : CE, WE, OE   active-low strobes, master -> slave
//           AD           address, master -> slave
//           ReadValid    slave -> master, DT carries valid read data
//           BusConflict  slave -> master, sticky conflict flag
//           WriteCount   slave -> master, saturating committed-write count
// The shared DT data bus is a tristate net and is wired as a direct inout
// port of the responder so both drivers resolve on one module-level net.
// ---------------------------------------------------------------------------
interface sram_responder_if #(
    parameter int ADDR_W = sram_responder_pkg::ADDR_W_DEF
);
    logic              CE;
    logic              WE;
    logic              OE;
    logic [ADDR_W-1:0] AD;
    logic              ReadValid;
    logic              BusConflict;
    logic [7:0]        WriteCount;

    modport master (output CE, WE, OE, AD, input ReadValid, BusConflict, WriteCount);
    modport slave  (input CE, WE, OE, AD, output ReadValid, BusConflict, WriteCount);
endinterface

// File: rtl/sram_responder_array.sv
// ---------------------------------------------------------------------------
// sram_responder_array  (sram_array)
// Purpose : DATA_W x 2^ADDR_W storage, registered write, combinational read,
//           every word cleared synchronously while i_srst is high.
// Ports   : i_clk, i_srst        clock / synchronous active-high clear
//           i_we, i_waddr, i_wdata write strobe, address, data
//           i_raddr, o_rdata      asynchronous read port
// ---------------------------------------------------------------------------
module sram_array #(
    parameter int ADDR_W = sram_responder_pkg::ADDR_W_DEF,
    parameter int DATA_W = sram_responder_pkg::DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] w_words [DEPTH];

    // One register per word: a whole-array clear in a single cycle cannot
    // map onto a block RAM anyway, so each word owns its own flops.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_W-1:0] r_word;
            always_ff @(posedge i_clk) begin
                if (i_srst)
                    r_word <= '0;
                else if (i_we && (i_waddr == ADDR_W'(gi)))
                    r_word <= i_wdata;
            end
            assign w_words[gi] = r_word;
        end
    endgenerate

    assign o_rdata = w_words[i_raddr];
endmodule

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
// Purpose : device end of the CE/WE/OE/AD/DT SRAM interface. Samples the
//           strobes once, runs the access FSM, holds the array and drives DT
//           on reads after READ_LATENCY cycles.
// Ports   : MasterClock  clock, all state on rising edge
//           Reset        synchronous, active-high
//           bus          sram_responder_if.slave (CE/WE/OE/AD in,
//                        ReadValid/BusConflict/WriteCount out)
//           DT           shared tristate data bus
// ---------------------------------------------------------------------------
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = READ_LATENCY_DEF
) (
    input  logic               MasterClock,
    input  logic               Reset,
    sram_responder_if.slave    bus,
    inout  wire  [DATA_W-1:0]  DT
);
    localparam logic [3:0] C_LAT = 4'(READ_LATENCY);

    logic              r_ce_s, r_we_s, r_oe_s;
    logic [ADDR_W-1:0] r_ad_s, r_ad_prev;
    logic [DATA_W-1:0] r_dt_s;
    state_t            r_state, w_state_next;
    logic [3:0]        r_cnt, w_cnt_next;
    logic              r_drive_en, r_read_valid, r_bus_conflict;
    logic [7:0]        r_wcount;
    logic [ADDR_W-1:0] r_wa;
    logic [DATA_W-1:0] r_wd;
    logic              w_commit, w_ad_changed, w_dt_oe;
    logic [DATA_W-1:0] w_rd_data;

    // Input sampling; r_ad_prev lets the FSM notice an address change.
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            r_ce_s    <= 1'b1;
            r_we_s    <= 1'b1;
            r_oe_s    <= 1'b1;
            r_ad_s    <= '0;
            r_ad_prev <= '0;
            r_dt_s    <= '0;
        end else begin
            r_ce_s    <= bus.CE;
            r_we_s    <= bus.WE;
            r_oe_s    <= bus.OE;
            r_ad_s    <= bus.AD;
            r_ad_prev <= r_ad_s;
            r_dt_s    <= DT;
        end
    end

    assign w_ad_changed = (r_ad_s != r_ad_prev);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_ce_s && !r_we_s) begin
                    w_state_next = ST_WRITE;
                end else if (!r_ce_s && !r_oe_s) begin
                    w_cnt_next   = C_LAT;
                    w_state_next = (C_LAT == 4'd0) ? ST_READ_DRIVE : ST_READ_WAIT;
                end
            end
            ST_WRITE: begin
                if (r_we_s || r_ce_s) w_state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_commit = 1'b1;
                if (!r_ce_s && !r_we_s) begin
                    w_state_next = ST_WRITE;
                end else if (!r_ce_s && !r_oe_s) begin
                    w_cnt_next   = C_LAT;
                    w_state_next = ST_READ_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_READ_WAIT: begin
                // Write beats read, but only while the chip is selected.
                if (r_ce_s)              w_state_next = ST_IDLE;
                else if (!r_we_s)        w_state_next = ST_WRITE;
                else if (r_oe_s)         w_state_next = ST_IDLE;
                else if (w_ad_changed)   w_cnt_next   = C_LAT;
                else if (r_cnt <= 4'd1)  w_state_next = ST_READ_DRIVE;
                else                     w_cnt_next   = r_cnt - 4'd1;
            end
            ST_READ_DRIVE: begin
                if (r_ce_s)              w_state_next = ST_IDLE;
                else if (!r_we_s)        w_state_next = ST_WRITE;
                else if (r_oe_s)         w_state_next = ST_IDLE;
                else if (w_ad_changed) begin
                    w_cnt_next   = C_LAT;
                    w_state_next = ST_READ_WAIT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 4'd0;
            r_drive_en     <= 1'b0;
            r_read_valid   <= 1'b0;
            r_bus_conflict <= 1'b0;
            r_wcount       <= 8'd0;
            r_wa           <= '0;
            r_wd           <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_drive_en   <= (w_state_next == ST_READ_DRIVE);
            r_read_valid <= (w_state_next == ST_READ_DRIVE);
            if (!bus.WE && r_drive_en)
                r_bus_conflict <= 1'b1;
            if (w_commit && (r_wcount != 8'(WCOUNT_MAX)))
                r_wcount <= r_wcount + 8'd1;
            // Track address/data whenever a write strobe is held, in any
            // state, so even a one-cycle pulse has something to commit and
            // the last value before release wins.
            if (!r_ce_s && !r_we_s) begin
                r_wa <= r_ad_s;
                r_wd <= r_dt_s;
            end
        end
    end

    sram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .i_clk   (MasterClock),
        .i_srst  (Reset),
        .i_we    (w_commit),
        .i_waddr (r_wa),
        .i_wdata (r_wd),
        .i_raddr (r_ad_s),
        .o_rdata (w_rd_data)
    );

    // Raw WE/CE gate the driver so DT is released the instant the
    // controller starts a write, without waiting for a clock edge.
    assign w_dt_oe = r_drive_en & bus.WE & ~bus.CE;
    assign DT      = w_dt_oe ? w_rd_data : {DATA_W{1'bz}};

    assign bus.ReadValid   = r_read_valid;
    assign bus.BusConflict = r_bus_conflict;
    assign bus.WriteCount  = r_wcount;
endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
// Directed bench: a READ_LATENCY=2 responder and a READ_LATENCY=0 twin share
// the same strobes; expected read data goes through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_sram_responder;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce, we, oe;
    logic [3:0] ad;
    logic       dt_en;
    logic [3:0] dt_drv;
    wire  [3:0] dt_bus;
    wire  [3:0] dt_bus0;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_mem [16];
    int         exp_wc;
    logic [3:0] exp_q [$];

    sram_responder_if #(.ADDR_W(4)) bus  ();
    sram_responder_if #(.ADDR_W(4)) bus0 ();

    assign bus.CE  = ce;  assign bus.WE  = we;  assign bus.OE  = oe;  assign bus.AD  = ad;
    assign bus0.CE = ce;  assign bus0.WE = we;  assign bus0.OE = oe;  assign bus0.AD = ad;
    assign dt_bus  = dt_en ? dt_drv : 4'bz;
    assign dt_bus0 = dt_en ? dt_drv : 4'bz;

    sram_responder #(.ADDR_W(4), .DATA_W(4), .READ_LATENCY(LAT)) dut (
        .MasterClock (clk), .Reset (rst), .bus (bus.slave), .DT (dt_bus));
    sram_responder #(.ADDR_W(4), .DATA_W(4), .READ_LATENCY(0)) dut0 (
        .MasterClock (clk), .Reset (rst), .bus (bus0.slave), .DT (dt_bus0));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_read(input logic [3:0] a);
        int k_main, k_lat0;
        logic [3:0] got_main, got_lat0, exp_d;
        exp_q.push_back(exp_mem[a]);
        ce = 1'b0; oe = 1'b0; we = 1'b1; ad = a; dt_en = 1'b0;
        tick();  // sampling edge
        k_main = -1; k_lat0 = -1; got_main = 4'h0; got_lat0 = 4'h0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k_lat0 < 0 && bus0.ReadValid) begin k_lat0 = k; got_lat0 = dt_bus0; end
            if (k_main < 0 && bus.ReadValid)  begin k_main = k; got_main = dt_bus;  end
            if (k_main >= 0 && k_lat0 >= 0) break;
        end
        exp_d = exp_q.pop_front();
        check("rd_latency", k_main, LAT + 1);
        check("rd_latency0", k_lat0, 1);
        check("rd_data", {28'd0, got_main}, {28'd0, exp_d});
        check("rd_data0", {28'd0, got_lat0}, {28'd0, exp_d});
        $display("read  ad=%0h data=%0h lat=%0d lat0=%0d", a, got_main, k_main, k_lat0);
        ce = 1'b1; oe = 1'b1;
        tick(); tick(); tick();
        check("rd_valid_drop", {31'd0, bus.ReadValid}, 32'd0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d, input int ncyc);
        ce = 1'b0; we = 1'b0; oe = 1'b1; ad = a; dt_drv = d; dt_en = 1'b1;
        for (int i = 0; i < ncyc; i++) tick();
        we = 1'b1; ce = 1'b1; dt_en = 1'b0;
        tick(); tick(); tick(); tick();
        exp_mem[a] = d;
        if (exp_wc < 255) exp_wc++;
        check("wr_count", {24'd0, bus.WriteCount}, exp_wc);
        $display("write ad=%0h data=%0h count=%0d", a, d, bus.WriteCount);
    endtask

    initial begin
        int k_rv;
        rst = 1'b1; ce = 1'b1; we = 1'b1; oe = 1'b1; ad = 4'h0; dt_en = 1'b0; dt_drv = 4'h0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 4'h0;
        exp_wc = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_valid", {31'd0, bus.ReadValid}, 32'd0);
        check("rst_conflict", {31'd0, bus.BusConflict}, 32'd0);
        check("rst_count", {24'd0, bus.WriteCount}, 32'd0);
        check("rst_count0", {24'd0, bus0.WriteCount}, 32'd0);

        // Read every address after reset: all zero.
        for (int a = 0; a < 16; a++) do_read(4'(a));
        check("count_after_reads", {24'd0, bus.WriteCount}, 32'd0);

        // Single write, then read back the written and a neighbouring word.
        do_write(4'h5, 4'hA, 3);
        do_read(4'h5);
        do_read(4'h6);

        // Back-to-back writes to address 3 with a single-cycle release.
        ce = 1'b0; oe = 1'b1; ad = 4'h3; dt_en = 1'b1;
        we = 1'b0; dt_drv = 4'h7; tick(); tick();
        we = 1'b1; tick();
        we = 1'b0; dt_drv = 4'h9; tick(); tick();
        we = 1'b1; ce = 1'b1; dt_en = 1'b0;
        tick(); tick(); tick(); tick();
        exp_mem[3] = 4'h9;
        exp_wc += 2;
        check("b2b_count", {24'd0, bus.WriteCount}, exp_wc);
        $display("write ad=3 data=7,9 back-to-back count=%0d", bus.WriteCount);
        do_read(4'h3);

        // Write during READ_DRIVE: DT released at once, conflict flagged.
        ce = 1'b0; oe = 1'b0; we = 1'b1; ad = 4'h5; dt_en = 1'b0;
        k_rv = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.ReadValid) begin k_rv = k; break; end
        end
        check("conf_reach_drive", {31'd0, (k_rv >= 0)}, 32'd1);
        we = 1'b0; dt_drv = 4'h3; dt_en = 1'b1;
        #1;
        check("conf_dt_release", {28'd0, dt_bus}, 32'h3);
        check("conf_dt_release0", {28'd0, dt_bus0}, 32'h3);
        check("conf_flag_before", {31'd0, bus.BusConflict}, 32'd0);
        tick();
        check("conf_flag", {31'd0, bus.BusConflict}, 32'd1);
        check("conf_flag0", {31'd0, bus0.BusConflict}, 32'd1);
        tick();
        check("conf_to_write", {31'd0, bus.ReadValid}, 32'd0);
        tick();
        we = 1'b1; ce = 1'b1; oe = 1'b1; dt_en = 1'b0;
        tick(); tick(); tick(); tick();
        exp_mem[5] = 4'h3;
        exp_wc++;
        check("conf_count", {24'd0, bus.WriteCount}, exp_wc);
        check("conf_sticky", {31'd0, bus.BusConflict}, 32'd1);
        $display("conflict ad=5 data=3 flag=%0d count=%0d", bus.BusConflict, bus.WriteCount);
        do_read(4'h5);

        // Reset in the middle of a write: nothing committed, all cleared.
        ce = 1'b0; we = 1'b0; oe = 1'b1; ad = 4'h2; dt_drv = 4'hF; dt_en = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; we = 1'b1; ce = 1'b1; dt_en = 1'b0;
        tick(); tick();
        for (int i = 0; i < 16; i++) exp_mem[i] = 4'h0;
        exp_wc = 0;
        check("mid_rst_count", {24'd0, bus.WriteCount}, 32'd0);
        check("mid_rst_conflict", {31'd0, bus.BusConflict}, 32'd0);
        check("mid_rst_valid", {31'd0, bus.ReadValid}, 32'd0);
        dt_en = 1'b1; dt_drv = 4'h0;
        #1;
        check("mid_rst_dt_free", {28'd0, dt_bus}, 32'd0);
        dt_en = 1'b0;
        $display("reset mid-write count=%0d conflict=%0d", bus.WriteCount, bus.BusConflict);
        do_read(4'h2);
        do_read(4'h5);
        do_read(4'h3);

        // 260 one-cycle write pulses: counter saturates.
        ce = 1'b0; oe = 1'b1; dt_en = 1'b1;
        for (int i = 0; i < 260; i++) begin
            we = 1'b0; ad = 4'(i); dt_drv = 4'(i + 1);
            tick();
            we = 1'b1;
            tick(); tick();
            exp_mem[4'(i)] = 4'(i + 1);
            if (exp_wc < 255) exp_wc++;
        end
        ce = 1'b1; dt_en = 1'b0;
        tick(); tick(); tick(); tick();
        check("sat_count", {24'd0, bus.WriteCount}, exp_wc);
        check("sat_count0", {24'd0, bus0.WriteCount}, 32'd255);
        $display("write burst 260 pulses count=%0d", bus.WriteCount);
        do_read(4'h3);
        do_read(4'hC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
